// File: rtl/comparator_iter_pkg.sv
// rtl/comparator_iter_pkg.sv - shared state encodings and result indices for comparator variants
package comparator_iter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit positions of the results inside a {ans2, ans1, ans0} vector.
    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    // $clog2 returns 0 for 1; a counter still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// rtl/comparator_chunk.sv - combinational CHUNK-bit magnitude compare, MSB-first cascade
//
// Ports:
//   x, y  [CHUNK-1:0]  operand chunks
//   gt, eq, lt         x>y, x==y, x<y (exactly one is high)
module comparator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Each bit uses the 1-bit cell equations (x&~y, ~x&y, ~(x^y)); a bit only
    // decides the result while all more-significant bits are still equal.
    always_comb begin
        logic g;
        logic e;
        logic l;
        g = 1'b0;
        e = 1'b1;
        l = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            g = g | (e & x[i] & ~y[i]);
            l = l | (e & ~x[i] & y[i]);
            e = e & ~(x[i] ^ y[i]);
        end
        gt = g;
        eq = e;
        lt = l;
    end

endmodule

// File: rtl/comparator_iter.sv
// rtl/comparator_iter.sv - iterative MSB-first magnitude comparator with valid/ready handshakes
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   a, b [WIDTH-1:0]      operands, sampled with signed_mode on accept
//   signed_mode           1 = two's-complement compare, 0 = unsigned
//   out_valid / out_ready result handshake
//   ans2, ans1, ans0      A>B, A==B, A<B; held after out_valid falls
module comparator_iter
    import comparator_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ans2,
    output logic             ans1,
    output logic             ans0
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2_min1(NCHUNK);
    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    IDX_TOP = CW'(NCHUNK - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("comparator_iter: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    idx;
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
    logic             last_chunk;
    logic [WIDTH-1:0] flip;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the rest of the datapath is mode-agnostic.
    assign flip       = signed_mode ? MSB_BIT : '0;
    assign last_chunk = (idx == '0);

    assign x = a_r[int'(idx) * CHUNK +: CHUNK];
    assign y = b_r[int'(idx) * CHUNK +: CHUNK];

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (x),
        .y  (y),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if (!c_eq || last_chunk) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            idx  <= '0;
            ans2 <= 1'b0;
            ans1 <= 1'b0;
            ans0 <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                a_r <= a ^ flip;
                b_r <= b ^ flip;
                idx <= IDX_TOP;
            end else if (state == S_CMP) begin
                if (c_gt) begin
                    {ans2, ans1, ans0} <= 3'b100;
                end else if (c_lt) begin
                    {ans2, ans1, ans0} <= 3'b001;
                end else if (last_chunk) begin
                    {ans2, ans1, ans0} <= 3'b010;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid) begin
            assert ($onehot({ans2, ans1, ans0}))
                else $error("comparator_iter: result not one-hot while out_valid");
        end
    end

endmodule
